// File: rtl/hud_pkg.sv
// Shared definitions for the HUD snapshot/BCD conversion block:
// default widths, HUD slot indices and the converter FSM encoding.
package hud_pkg;

    // Default geometry: six 8-bit HUD values, three BCD digits each.
    localparam int NUM_VALUES_DEF = 6;
    localparam int IN_W_DEF       = 8;
    localparam int DIGITS_DEF     = 3;

    // Slot order inside in_values / bcd_out.
    localparam int SLOT_ENEMY_HP    = 0;
    localparam int SLOT_PLAYER_HP   = 1;
    localparam int SLOT_PLAYER_BAT  = 2;
    localparam int SLOT_PLAYER_SWRD = 3;
    localparam int SLOT_ENEMY_BAT   = 4;
    localparam int SLOT_ENEMY_SWRD  = 5;

    // Converter sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_STORE  = 3'd3,
        ST_COMMIT = 3'd4
    } state_e;

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble iteration: every BCD digit >= 5 gets +3
// (no carry between digits), then {bcd, shift} moves left by one bit.
module bcd_dabble_step
    import hud_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int IN_W   = IN_W_DEF
) (
    input  logic [DIGITS*4-1:0] bcd_in,
    input  logic [IN_W-1:0]     shift_in,
    output logic [DIGITS*4-1:0] bcd_out,
    output logic [IN_W-1:0]     shift_out
);

    localparam int DW = DIGITS * 4;

    logic [DW-1:0]      adj;
    logic [DW+IN_W-1:0] shifted;

    // Per-digit add-3 correction; each nibble wraps within 4 bits.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign adj[gi*4 +: 4] = (bcd_in[gi*4 +: 4] >= 4'd5)
                                  ? bcd_in[gi*4 +: 4] + 4'd3
                                  : bcd_in[gi*4 +: 4];
        end
    endgenerate

    // The MSB of the corrected digits falls off the top; it is always 0
    // when 10^DIGITS exceeds the largest input value.
    assign shifted   = {adj, shift_in} << 1;
    assign bcd_out   = shifted[DW+IN_W-1 : IN_W];
    assign shift_out = shifted[IN_W-1:0];

endmodule

// File: rtl/hud_bcd_latch.sv
// Frame-synchronous HUD latch: snapshots all values on frame_start, converts
// them one at a time to BCD, then publishes every digit on a single edge so
// the renderer never sees a partially updated set.
module hud_bcd_latch
    import hud_pkg::*;
#(
    parameter int NUM_VALUES = NUM_VALUES_DEF,
    parameter int IN_W       = IN_W_DEF,
    parameter int DIGITS     = DIGITS_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           frame_start,
    input  logic [NUM_VALUES*IN_W-1:0]     in_values,
    output logic [NUM_VALUES*DIGITS*4-1:0] bcd_out,
    output logic                           valid,
    output logic                           busy,
    output logic                           overrun
);

    localparam int DW    = DIGITS * 4;
    localparam int IDX_W = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    state_e                        state_q, state_d;
    logic [NUM_VALUES*IN_W-1:0]    snap_q, snap_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [CNT_W-1:0]              bit_cnt_q, bit_cnt_d;
    logic [IN_W-1:0]               shift_q, shift_d;
    logic [DW-1:0]                 acc_q, acc_d;
    logic [NUM_VALUES*DW-1:0]      work_q, work_d;
    logic [NUM_VALUES*DW-1:0]      bcd_out_q, bcd_out_d;
    logic                          valid_q, valid_d;
    logic                          busy_q, busy_d;
    logic                          overrun_q, overrun_d;

    logic [DW-1:0]                 step_bcd;
    logic [IN_W-1:0]               step_shift;

    bcd_dabble_step #(
        .DIGITS (DIGITS),
        .IN_W   (IN_W)
    ) u_step (
        .bcd_in    (acc_q),
        .shift_in  (shift_q),
        .bcd_out   (step_bcd),
        .shift_out (step_shift)
    );

    // Next-state logic for the converter FSM and its datapath registers.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        work_d    = work_q;
        bcd_out_d = bcd_out_q;
        valid_d   = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    snap_d  = in_values;
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_d   = snap_q[idx_q*IN_W +: IN_W];
                acc_d     = '0;
                bit_cnt_d = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                acc_d   = step_bcd;
                shift_d = step_shift;
                if (bit_cnt_q == CNT_W'(IN_W - 1)) begin
                    state_d = ST_STORE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_STORE: begin
                work_d[idx_q*DW +: DW] = acc_q;
                if (idx_q == IDX_W'(NUM_VALUES - 1)) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_COMMIT: begin
                bcd_out_d = work_q;
                valid_d   = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Status flags are registered copies of the upcoming state.
        busy_d    = (state_d != ST_IDLE);
        overrun_d = frame_start && (state_q != ST_IDLE);
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            snap_q    <= '0;
            idx_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            acc_q     <= '0;
            work_q    <= '0;
            bcd_out_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            work_q    <= work_d;
            bcd_out_q <= bcd_out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign bcd_out = bcd_out_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_hud_bcd_latch.sv
// Scoreboard bench for hud_bcd_latch: expected digit sets are queued when a
// frame is launched and compared when the block reports the commit.
module tb_hud_bcd_latch;

    localparam int NV  = 6;
    localparam int IW  = 8;
    localparam int OW  = NV * 12;
    localparam int LAT = 61;

    logic          clk;
    logic          rst_n;
    logic          frame_start;
    logic [NV*IW-1:0] in_values;
    logic [OW-1:0] bcd_out;
    logic          valid;
    logic          busy;
    logic          overrun;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] last_commit;
    int            n_tests;
    int            n_fail;

    hud_bcd_latch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .in_values   (in_values),
        .bcd_out     (bcd_out),
        .valid       (valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic check_val(input string tag, input logic [OW-1:0] obs,
                             input logic [OW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [NV*IW-1:0] pack6(input int a, input int b, input int c,
                                               input int d, input int e, input int f);
        logic [NV*IW-1:0] v;
        v = {IW'(f), IW'(e), IW'(d), IW'(c), IW'(b), IW'(a)};
        return v;
    endfunction

    // Decimal reference: hundreds/tens/ones per slot.
    function automatic logic [OW-1:0] to_bcd(input logic [NV*IW-1:0] vals);
        logic [OW-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < NV; i++) begin
            v = int'(vals[i*IW +: IW]);
            r[i*12 +: 12] = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        end
        return r;
    endfunction

    // Launch one frame at the next edge (E0), optionally inject extra
    // frame_start pulses at edges fs_a/fs_b and change slot 0 at edge chg_k.
    task automatic run_frame(input string name, input logic [NV*IW-1:0] vals,
                             input int fs_a, input int fs_b,
                             input int chg_k, input logic [7:0] chg_val);
        int lat;
        logic [OW-1:0] exp;
        lat = -1;
        in_values   = vals;
        frame_start = 1'b1;
        exp_q.push_back(to_bcd(vals));
        @(posedge clk);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) check_val({name, "_busy_e0"}, OW'(busy), OW'(1));
            frame_start = (k == fs_a) || (k == fs_b);
            if (k == chg_k) in_values[7:0] = chg_val;
            @(posedge clk);
            #1;
            check_val({name, "_overrun"}, OW'(overrun), OW'((k == fs_a) || (k == fs_b)));
            if (!busy) begin
                lat = k;
                break;
            end
            check_val({name, "_hold"}, bcd_out, last_commit);
        end
        frame_start = 1'b0;
        check_val({name, "_latency"}, OW'(lat), OW'(LAT));
        check_val({name, "_sb_size"}, OW'(exp_q.size()), OW'(1));
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check_val({name, "_bcd"}, bcd_out, exp);
            check_val({name, "_valid"}, OW'(valid), OW'(1));
            last_commit = exp;
        end
    endtask

    initial begin
        logic [NV*IW-1:0] va;
        logic [NV*IW-1:0] vs;
        n_tests     = 0;
        n_fail      = 0;
        last_commit = '0;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        in_values   = pack6(255, 0, 100, 3, 2, 1);

        // Held in reset with frame_start pulses: nothing may move.
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            frame_start = (c % 7 == 0);
            if (c % 25 == 0) begin
                check_val("rst_bcd", bcd_out, '0);
                check_val("rst_valid", OW'(valid), OW'(0));
                check_val("rst_busy", OW'(busy), OW'(0));
                check_val("rst_overrun", OW'(overrun), OW'(0));
            end
        end
        frame_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_valid", OW'(valid), OW'(0));

        // Basic frame.
        va = pack6(255, 0, 100, 3, 2, 1);
        run_frame("basic", va, -1, -1, -1, 8'd0);

        // Slot 0 changed after the snapshot: commit still shows 255.
        run_frame("late_chg", va, -1, -1, 5, 8'd7);

        // Next frame sees the new value; rejected starts at E30 and E61.
        va = pack6(7, 0, 100, 3, 2, 1);
        run_frame("overrun", va, 30, 61, -1, 8'd0);

        // Back-to-back accept at E62.
        run_frame("b2b", pack6(42, 199, 8, 60, 11, 250), -1, -1, -1, 8'd0);

        // Reset in the middle of a conversion.
        in_values   = pack6(1, 2, 3, 4, 5, 6);
        frame_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_start = 1'b0;
        repeat (39) @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_bcd", bcd_out, '0);
        check_val("abort_valid", OW'(valid), OW'(0));
        check_val("abort_busy", OW'(busy), OW'(0));
        last_commit = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("abort_idle", OW'(busy), OW'(0));
        run_frame("after_rst", pack6(9, 99, 0, 10, 109, 190), -1, -1, -1, 8'd0);

        // Sweep slot 0 over its full range, other slots varied.
        for (int v = 0; v < 256; v++) begin
            vs = pack6(v, 255 - v, $urandom_range(0, 255), $urandom_range(0, 255),
                       $urandom_range(0, 255), (v * 37) % 256);
            run_frame("sweep", vs, -1, -1, -1, 8'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
